aes_clock_controller: RTL and testbench

Sequences the clock and reset resource for the AES core. Synchronizes the board-level asynchronous active-low reset, holds the core in reset for a fixed settling time, then issues a programmable-rate clock-enable pulse train under a run/halt handshake. It sits between the top-level clock/reset source and the AES round datapath. The core advances one step per `clk_en` pulse, so the datapath runs at a controlled fraction of `clock` without a second clock domain.

---
 rtl/aes_clock_controller_if.sv | 25 ++
 rtl/aes_clock_controller.sv | 138 +++++++++++++
 tb/tb_aes_clock_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aes_clock_controller_if.sv
// Run/halt handshake and clock-enable outputs of the AES clock controller.
// The requester (sequencer or bench) holds the master side; the controller
// holds the slave side.
interface aes_clock_controller_if #(
   parameter int DIV_WIDTH = 8
);
   logic [DIV_WIDTH-1:0] div_ratio;
   logic                 run_req;
   logic                 halt_req;
   logic                 core_reset_n;
   logic                 clk_en;
   logic                 ready;
   logic                 busy;
   logic [15:0]          tick_count;

   modport master (
      output div_ratio, run_req, halt_req,
      input  core_reset_n, clk_en, ready, busy, tick_count
   );

   modport slave (
      input  div_ratio, run_req, halt_req,
      output core_reset_n, clk_en, ready, busy, tick_count
   );
endinterface

// File: rtl/aes_clock_controller.sv
// Clock/reset sequencer for the AES core. It synchronizes the board reset,
// then stretches it by HOLD_CYCLES. After that it issues a programmable-rate,
// one-cycle clk_en pulse train under a run/halt handshake, so the datapath
// advances at a fraction of clock without a second clock domain.
module aes_clock_controller #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int DIV_WIDTH   = 8
) (
   input logic                   clock,
   input logic                   reset,
   aes_clock_controller_if.slave ctrl
);

   localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [15:0] TICK_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_rst_n;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [DIV_WIDTH-1:0]   div_cnt;
   logic [DIV_WIDTH-1:0]   ratio_q;
   logic                   halt_pending;
   logic                   core_reset_n_q;
   logic                   clk_en_q;
   logic                   ready_q;
   logic                   busy_q;
   logic [15:0]            tick_q;

   // Reset synchronizer: ones shift in after release, zeros load at once on assert.
   // NOTE: assertion is asynchronous so the core is stopped even without a
   // running clock; release goes through the chain so every flop leaves reset
   // on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignment for all state so every flop samples
         // pre-edge values regardless of statement order.
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_rst_n = sync_q[SYNC_STAGES-1];

   // Sequencer FSM: reset stretch, run/halt handshake, divider and pulse counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ST_HOLD;
         hold_cnt       <= '0;
         div_cnt        <= '0;
         ratio_q        <= '0;
         halt_pending   <= 1'b0;
         core_reset_n_q <= 1'b0;
         clk_en_q       <= 1'b0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
         tick_q         <= '0;
      end else begin
         case (state)
            ST_HOLD: begin
               // Count only once the synchronized reset has released.
               if (sync_rst_n) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state          <= ST_IDLE;
                     core_reset_n_q <= 1'b1;
                     ready_q        <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               // Halt has priority over a simultaneous run request.
               if (ctrl.run_req && !ctrl.halt_req) begin
                  state        <= ST_RUN;
                  ready_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  div_cnt      <= '0;
                  ratio_q      <= ctrl.div_ratio;
                  tick_q       <= '0;
                  halt_pending <= 1'b0;
               end
            end

            ST_RUN: begin
               if (ctrl.halt_req) begin
                  halt_pending <= 1'b1;
               end

               if (clk_en_q && halt_pending) begin
                  // The pulse now ending was the last one owed to the halt.
                  state    <= ST_IDLE;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  clk_en_q <= 1'b0;
                  div_cnt  <= '0;
               end else if (div_cnt == ratio_q) begin
                  // Period boundary: emit a pulse and pick up any new ratio.
                  clk_en_q <= 1'b1;
                  div_cnt  <= '0;
                  ratio_q  <= ctrl.div_ratio;
                  if (tick_q != TICK_MAX) begin
                     tick_q <= tick_q + 16'd1;
                  end
               end else begin
                  clk_en_q <= 1'b0;
                  div_cnt  <= div_cnt + 1'b1;
               end
            end

            default: begin
               state          <= ST_HOLD;
               core_reset_n_q <= 1'b0;
               clk_en_q       <= 1'b0;
               ready_q        <= 1'b0;
               busy_q         <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl.core_reset_n = core_reset_n_q;
   assign ctrl.clk_en       = clk_en_q;
   assign ctrl.ready        = ready_q;
   assign ctrl.busy         = busy_q;
   assign ctrl.tick_count   = tick_q;

endmodule

// File: tb/tb_aes_clock_controller.sv
// Directed bench for aes_clock_controller: reset stretch, pulse spacing,
// halt behaviour, ratio change at a period boundary, run/halt priority and
// an asynchronous reset in the middle of a run.
module tb_aes_clock_controller;

   logic clock;
   logic reset;
   int   n_cmp = 0;
   int   n_mis = 0;

   aes_clock_controller_if #(.DIV_WIDTH(8)) bus ();

   aes_clock_controller #(
      .SYNC_STAGES(2),
      .HOLD_CYCLES(16),
      .DIV_WIDTH  (8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .ctrl (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int bad;
      int steps;
      int pulses;

      // NOTE: stimulus is driven with blocking assignments 1 time unit after
      // the edge, so the DUT never sees a race with its own sampling.
      reset        = 1'b0;
      bus.div_ratio = 8'd0;
      bus.run_req  = 1'b0;
      bus.halt_req = 1'b0;

      // Power-up: reset low for 3 cycles.
      repeat (3) step();
      check("rst_core_reset_n", bus.core_reset_n, 1'b0);
      check("rst_clk_en",       bus.clk_en,       1'b0);
      check("rst_ready",        bus.ready,        1'b0);
      check("rst_busy",         bus.busy,         1'b0);
      check("rst_tick",         bus.tick_count,   16'd0);

      // Release; core reset must stay low through edge 17, rise at 18.
      reset = 1'b1;
      bad = 0;
      for (int e = 1; e <= 17; e++) begin
         step();
         if (bus.core_reset_n !== 1'b0 || bus.ready !== 1'b0 || bus.clk_en !== 1'b0) bad++;
      end
      check("hold_low_edges_1_17", bad, 0);
      step();
      check("edge18_core_reset_n", bus.core_reset_n, 1'b1);
      check("edge18_ready",        bus.ready,        1'b1);
      check("edge18_busy",         bus.busy,         1'b0);
      check("edge18_clk_en",       bus.clk_en,       1'b0);

      // Ratio 3: pulse every 4 cycles, first one 4 edges after acceptance.
      bus.div_ratio = 8'd3;
      bus.run_req   = 1'b1;
      step();
      bus.run_req = 1'b0;
      check("r3_accept_busy",  bus.busy,       1'b1);
      check("r3_accept_ready", bus.ready,      1'b0);
      check("r3_accept_tick",  bus.tick_count, 16'd0);
      for (int i = 1; i <= 20; i++) begin
         step();
         check($sformatf("r3_clk_en_edge%0d", i), bus.clk_en, (i % 4 == 0));
      end
      check("r3_tick_after_5", bus.tick_count, 16'd5);

      // Halt with ratio 3: one more pulse, then IDLE on the edge ending it.
      bus.halt_req = 1'b1;
      step();
      bus.halt_req = 1'b0;
      steps  = 0;
      pulses = 0;
      while (bus.ready !== 1'b1 && steps < 12) begin
         step();
         steps++;
         if (bus.clk_en === 1'b1) pulses++;
      end
      check("r3_halt_latency", steps,          4);
      check("r3_halt_pulses",  pulses,         1);
      check("r3_halt_busy",    bus.busy,       1'b0);
      check("r3_halt_tick",    bus.tick_count, 16'd6);

      // Run and halt together in IDLE: halt wins.
      bus.run_req  = 1'b1;
      bus.halt_req = 1'b1;
      repeat (2) step();
      bus.run_req  = 1'b0;
      bus.halt_req = 1'b0;
      check("both_ready",  bus.ready,      1'b1);
      check("both_busy",   bus.busy,       1'b0);
      check("both_tick",   bus.tick_count, 16'd6);
      check("both_clk_en", bus.clk_en,     1'b0);

      // Ratio 0: continuous enable, then exactly one more cycle after halt.
      bus.div_ratio = 8'd0;
      bus.run_req   = 1'b1;
      step();
      bus.run_req = 1'b0;
      check("r0_accept_tick", bus.tick_count, 16'd0);
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus.clk_en !== 1'b1) bad++;
      end
      check("r0_continuous", bad, 0);
      check("r0_tick_10", bus.tick_count, 16'd10);
      bus.halt_req = 1'b1;
      step();
      bus.halt_req = 1'b0;
      check("r0_last_pulse", bus.clk_en,     1'b1);
      check("r0_last_busy",  bus.busy,       1'b1);
      step();
      check("r0_stop_clk_en", bus.clk_en,     1'b0);
      check("r0_stop_ready",  bus.ready,      1'b1);
      check("r0_stop_busy",   bus.busy,       1'b0);
      check("r0_stop_tick",   bus.tick_count, 16'd11);
      repeat (3) step();
      check("r0_frozen_tick",   bus.tick_count, 16'd11);
      check("r0_frozen_clk_en", bus.clk_en,     1'b0);

      // Ratio 2 changed to 5 mid-period: pulses at 3, 6, then every 6.
      bus.div_ratio = 8'd2;
      bus.run_req   = 1'b1;
      step();
      bus.run_req = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         step();
         check($sformatf("r2to5_clk_en_edge%0d", i), bus.clk_en,
               (i == 3 || i == 6 || i == 12 || i == 18 || i == 24));
         if (i == 4) bus.div_ratio = 8'd5;
      end
      check("r2to5_tick", bus.tick_count, 16'd5);

      // Reset mid-RUN between edges, while a pulse is high.
      #2;
      reset = 1'b0;
      #1;
      check("midrst_clk_en",       bus.clk_en,       1'b0);
      check("midrst_busy",         bus.busy,         1'b0);
      check("midrst_ready",        bus.ready,        1'b0);
      check("midrst_core_reset_n", bus.core_reset_n, 1'b0);
      check("midrst_tick",         bus.tick_count,   16'd0);
      step();
      reset = 1'b1;
      bad = 0;
      for (int e = 1; e <= 17; e++) begin
         step();
         if (bus.core_reset_n !== 1'b0 || bus.clk_en !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      check("rehold_low_edges_1_17", bad, 0);
      step();
      check("rehold_core_reset_n", bus.core_reset_n, 1'b1);
      check("rehold_ready",        bus.ready,        1'b1);
      check("rehold_tick",         bus.tick_count,   16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
